// File: rtl/ram_test_pkg.sv
// Shared types and constants for the RAM pattern tester: FSM states, pattern
// selection, LFSR definition and LED bit positions.
package ram_test_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWriteGap,
        StRead,
        StReadGap,
        StCompare,
        StFail
    } state_e;

    typedef enum logic [1:0] {
        PATTERN_INDEX,
        PATTERN_INVERTED,
        PATTERN_LFSR
    } pattern_e;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [1:0] LAST_PASS = 2'd2;

    localparam int unsigned LED_HEARTBEAT = 7;
    localparam int unsigned LED_MISMATCH  = 6;
    localparam int unsigned LED_TIMEOUT   = 5;
    localparam int unsigned LED_PASS_HI   = 4;
    localparam int unsigned LED_PASS_LO   = 3;
    localparam int unsigned LED_INDEX_HI  = 2;

    function automatic pattern_e pass_to_pattern(input logic [1:0] pass);
        case (pass)
            2'd0:    return PATTERN_INDEX;
            2'd1:    return PATTERN_INVERTED;
            default: return PATTERN_LFSR;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ram_pattern_tester_if.sv
// Wishbone-classic bus between the pattern tester (master) and the RAM slave.
interface ram_pattern_tester_if;

    logic        wb_cycle_strobe;
    logic        wb_write_enable;
    logic [31:0] wb_address;
    logic [31:0] wb_write_data;
    logic [31:0] wb_read_data;
    logic        wb_ack;

    modport master (
        output wb_cycle_strobe,
        output wb_write_enable,
        output wb_address,
        output wb_write_data,
        input  wb_read_data,
        input  wb_ack
    );

    modport slave (
        input  wb_cycle_strobe,
        input  wb_write_enable,
        input  wb_address,
        input  wb_write_data,
        output wb_read_data,
        output wb_ack
    );

endinterface

// File: rtl/ram_test_pattern_gen.sv
// Produces the write/expected word for the current pass and index; one instance
// serves both the write and read-back phases.
module ram_test_pattern_gen
    import ram_test_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  i_pass,
    input  logic [31:0] i_index,
    input  logic        i_advance,
    input  logic        i_reseed,
    output logic [31:0] o_pattern
);

    logic [31:0] r_lfsr;
    pattern_e    w_sel;

    always_ff @(posedge clock) begin
        if (reset || i_reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    always_comb begin
        w_sel = pass_to_pattern(i_pass);
        case (w_sel)
            PATTERN_INDEX:    o_pattern = i_index;
            PATTERN_INVERTED: o_pattern = ~i_index;
            default:          o_pattern = r_lfsr;
        endcase
    end

endmodule

// File: rtl/ram_pattern_tester.sv
// Wishbone master that writes, reads back and checks three data patterns over a
// RAM window in a continuous loop, reporting status on the board LEDs.
module ram_pattern_tester
    import ram_test_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter logic [31:0] ADDRESS_BASE   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                        clock,
    input  logic                        reset,
    ram_pattern_tester_if.master        io_wb,
    output logic [7:0]                  o_leds,
    output logic                        o_done_ok,
    output logic                        o_failed
);

    state_e                   r_state;
    state_e                   w_state_next;
    logic [ADDRESS_WIDTH-1:0] r_index;
    logic [ADDRESS_WIDTH-1:0] w_index_next;
    logic [1:0]               r_pass;
    logic [1:0]               w_pass_next;
    logic                     r_round;
    logic                     w_round_next;
    logic [15:0]              r_tmo;
    logic [15:0]              w_tmo_next;
    logic [31:0]              r_rdata;
    logic                     r_stb;
    logic                     r_we;
    logic                     r_mismatch;
    logic                     r_timeout;
    logic                     r_failed;
    logic                     r_done;

    logic        w_capture;
    logic        w_advance;
    logic        w_reseed;
    logic        w_done_next;
    logic        w_mismatch_set;
    logic        w_timeout_set;
    logic        w_tmo_hit;
    logic        w_index_last;
    logic [31:0] w_index32;
    logic [31:0] w_pattern;

    assign w_index32    = 32'(r_index);
    assign w_index_last = (r_index == {ADDRESS_WIDTH{1'b1}});
    // Another wait cycle without ack would reach the limit.
    assign w_tmo_hit    = (({1'b0, r_tmo} + 17'd1) == 17'(TIMEOUT_CYCLES));

    ram_test_pattern_gen u_pattern_gen (
        .clock     (clock),
        .reset     (reset),
        .i_pass    (r_pass),
        .i_index   (w_index32),
        .i_advance (w_advance),
        .i_reseed  (w_reseed),
        .o_pattern (w_pattern)
    );

    always_comb begin
        w_state_next   = r_state;
        w_index_next   = r_index;
        w_pass_next    = r_pass;
        w_round_next   = r_round;
        w_tmo_next     = '0;
        w_capture      = 1'b0;
        w_advance      = 1'b0;
        w_reseed       = 1'b0;
        w_done_next    = 1'b0;
        w_mismatch_set = 1'b0;
        w_timeout_set  = 1'b0;
        case (r_state)
            StIdle: begin
                w_index_next = '0;
                w_reseed     = 1'b1;
                w_state_next = StWrite;
            end
            StWrite: begin
                if (io_wb.wb_ack) begin
                    w_state_next = StWriteGap;
                end else if (w_tmo_hit) begin
                    w_state_next  = StFail;
                    w_timeout_set = 1'b1;
                end else begin
                    w_tmo_next = r_tmo + 16'd1;
                end
            end
            StWriteGap: begin
                w_index_next = r_index + 1'b1;
                if (w_index_last) begin
                    w_reseed     = 1'b1;
                    w_state_next = StRead;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = StWrite;
                end
            end
            StRead: begin
                if (io_wb.wb_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = StCompare;
                end else if (w_tmo_hit) begin
                    w_state_next  = StFail;
                    w_timeout_set = 1'b1;
                end else begin
                    w_tmo_next = r_tmo + 16'd1;
                end
            end
            StCompare: begin
                if (r_rdata != w_pattern) begin
                    w_state_next   = StFail;
                    w_mismatch_set = 1'b1;
                end else begin
                    w_state_next = StReadGap;
                end
            end
            StReadGap: begin
                w_index_next = r_index + 1'b1;
                if (w_index_last) begin
                    w_reseed     = 1'b1;
                    w_state_next = StIdle;
                    if (r_pass == LAST_PASS) begin
                        w_pass_next  = '0;
                        w_round_next = ~r_round;
                        w_done_next  = 1'b1;
                    end else begin
                        w_pass_next = r_pass + 2'd1;
                    end
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = StRead;
                end
            end
            StFail: begin
                w_state_next = StFail;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_index    <= '0;
            r_pass     <= '0;
            r_round    <= 1'b0;
            r_tmo      <= '0;
            r_rdata    <= '0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
            r_failed   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_index    <= w_index_next;
            r_pass     <= w_pass_next;
            r_round    <= w_round_next;
            r_tmo      <= w_tmo_next;
            r_stb      <= (w_state_next == StWrite) || (w_state_next == StRead);
            r_we       <= (w_state_next == StWrite);
            r_mismatch <= r_mismatch | w_mismatch_set;
            r_timeout  <= r_timeout | w_timeout_set;
            r_failed   <= r_failed | (w_state_next == StFail);
            r_done     <= w_done_next;
            if (w_capture) begin
                r_rdata <= io_wb.wb_read_data;
            end
        end
    end

    // Address and data derive only from registers that change outside strobe.
    assign io_wb.wb_cycle_strobe = r_stb;
    assign io_wb.wb_write_enable = r_we;
    assign io_wb.wb_address      = ADDRESS_BASE + w_index32;
    assign io_wb.wb_write_data   = w_pattern;

    always_comb begin
        o_leds                            = '0;
        o_leds[LED_HEARTBEAT]             = r_round;
        o_leds[LED_MISMATCH]              = r_mismatch;
        o_leds[LED_TIMEOUT]               = r_timeout;
        o_leds[LED_PASS_HI:LED_PASS_LO]   = r_pass;
        o_leds[LED_INDEX_HI:0]            = w_index32[2:0];
    end

    assign o_done_ok = r_done;
    assign o_failed  = r_failed;

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Directed bench for ram_pattern_tester with a 4-word RAM model whose ack
// behaviour and read corruption are selectable per test.
module tb_ram_pattern_tester;

    localparam int unsigned AW   = 2;
    localparam logic [31:0] BASE = 32'h0000_0010;
    localparam int unsigned TMO  = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] leds;
    logic       done_ok;
    logic       failed;

    ram_pattern_tester_if bus ();

    ram_pattern_tester #(
        .ADDRESS_WIDTH  (AW),
        .ADDRESS_BASE   (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_wb     (bus),
        .o_leds    (leds),
        .o_done_ok (done_ok),
        .o_failed  (failed)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    // 0: ack in second strobe cycle, 1: never ack, 2: ack toggles every cycle
    int          mode       = 0;
    bit          corrupt_en = 1'b0;
    bit          hold_en    = 1'b0;
    int          hold_err   = 0;
    int          rd_count   = 0;
    logic        ack_r      = 1'b0;
    logic [31:0] mem [0:3];
    logic [63:0] wlog [$];

    logic [31:0] exp_wr [0:11] = '{
        32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
        32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC,
        32'h0000_0001, 32'h0000_0003, 32'h0000_0006, 32'h0000_000D
    };

    wire [1:0] midx = bus.wb_address[1:0];

    assign bus.wb_ack       = ack_r;
    assign bus.wb_read_data = (corrupt_en && rd_count == 6) ? (mem[midx] ^ 32'h1) : mem[midx];

    always @(posedge clock) begin
        if (reset) begin
            ack_r    <= 1'b0;
            rd_count <= 0;
        end else begin
            if (bus.wb_cycle_strobe && ack_r) begin
                if (bus.wb_write_enable) begin
                    mem[midx] <= bus.wb_write_data;
                    wlog.push_back({bus.wb_address, bus.wb_write_data});
                end else begin
                    rd_count <= rd_count + 1;
                end
            end
            case (mode)
                0:       ack_r <= bus.wb_cycle_strobe && !ack_r;
                1:       ack_r <= 1'b0;
                default: ack_r <= ~ack_r;
            endcase
        end
    end

    logic        p_wait = 1'b0;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_data;

    always @(negedge clock) begin
        if (hold_en && !reset && p_wait) begin
            if (!bus.wb_cycle_strobe || bus.wb_address !== p_addr ||
                bus.wb_write_enable !== p_we || (p_we && bus.wb_write_data !== p_data)) begin
                hold_err <= hold_err + 1;
            end
        end
        p_wait <= !reset && bus.wb_cycle_strobe && !bus.wb_ack;
        p_we   <= bus.wb_write_enable;
        p_addr <= bus.wb_address;
        p_data <= bus.wb_write_data;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        wlog.delete();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done_ok) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, " write count"}, wlog.size(), 12);
        for (int i = 0; i < 12 && i < wlog.size(); i++) begin
            check($sformatf("%s addr %0d", tag, i), wlog[i][63:32], BASE + 32'(i % 4));
            check($sformatf("%s data %0d", tag, i), wlog[i][31:0], exp_wr[i]);
        end
    endtask

    initial begin
        bit seen;
        int n;

        // Reset values, then one clean round with ack-next-cycle memory.
        mode = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst strobe", bus.wb_cycle_strobe, 0);
        check("rst we", bus.wb_write_enable, 0);
        check("rst addr", bus.wb_address, BASE);
        check("rst wdata", bus.wb_write_data, 0);
        check("rst leds", leds, 8'h00);
        check("rst failed", failed, 0);
        check("rst done", done_ok, 0);
        wlog.delete();
        reset = 1'b0;
        wait_done(400, seen);
        check("clean done seen", seen, 1);
        check("clean leds", leds, 8'h80);
        check("clean failed", failed, 0);
        check_writes("clean");
        @(negedge clock);
        check("done one cycle", done_ok, 0);

        // Read corruption at index 2 of pass 1.
        corrupt_en = 1'b1;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            seen = failed;
        end
        check("corrupt failed", seen, 1);
        check("corrupt leds", leds, 8'h4A);
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.wb_cycle_strobe) n++;
        end
        check("corrupt strobe idle", n, 0);
        check("corrupt leds frozen", leds, 8'h4A);
        corrupt_en = 1'b0;

        // Never-acking memory hits the timeout.
        mode = 1;
        do_reset();
        for (int i = 0; i < 10 && !bus.wb_cycle_strobe; i++) @(negedge clock);
        check("tmo first we", bus.wb_write_enable, 1);
        n = 0;
        while (bus.wb_cycle_strobe && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("tmo strobe cycles", n, TMO);
        check("tmo failed", failed, 1);
        check("tmo leds", leds, 8'h20);

        // Toggling ack: clean round and stable bus while waiting.
        mode = 2;
        hold_en = 1'b1;
        do_reset();
        wait_done(600, seen);
        check("toggle done seen", seen, 1);
        check("toggle failed", failed, 0);
        check_writes("toggle");
        hold_en = 1'b0;
        @(negedge clock);
        check("toggle hold errors", hold_err, 0);

        // Reset during a read with strobe high.
        mode = 0;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            seen = bus.wb_cycle_strobe && !bus.wb_write_enable;
        end
        check("mid read reached", seen, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid reset strobe", bus.wb_cycle_strobe, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10 && !bus.wb_cycle_strobe; i++) @(negedge clock);
        check("post reset strobe", bus.wb_cycle_strobe, 1);
        check("post reset we", bus.wb_write_enable, 1);
        check("post reset addr", bus.wb_address, BASE);
        check("post reset wdata", bus.wb_write_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
